// File: rtl/wb_write_arbiter.sv
// Single register-file write port shared by the MEM-WB stage and a long-latency unit.
// The pipeline normally wins; a starved LLU result forces a one-cycle pipeline stall.
module wb_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        llu_valid,
  input  logic [4:0]  llu_reg,
  input  logic [31:0] llu_data,
  output logic        llu_ready,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic        pipe_wants;
  logic        forced;
  logic        llu_hs;

  logic [3:0]  wait_q, wait_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Arbitration; gated by rst so nothing handshakes while held in reset.
  always_comb begin
    pipe_wants = wb_RegWrite && (wb_reg != 5'd0);
    forced     = rst && pipe_wants && llu_valid && (wait_q == Limit);
    llu_ready  = rst && (!pipe_wants || forced);
    stall_req  = forced;
    llu_hs     = llu_valid && llu_ready;
  end

  // Write-port selection. On a forced grant the pipeline write is simply
  // dropped: MEM-WB is stalled and re-presents it next cycle.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (llu_hs) begin
      if (llu_reg != 5'd0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = llu_reg;
        rf_wdata_d = llu_data;
      end
    end else if (pipe_wants) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_reg;
      rf_wdata_d = wb_data;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (!llu_valid || llu_hs) begin
      wait_d = 4'd0;
    end else if (wait_q < Limit) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_req && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q      <= 4'd0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= 32'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      wait_q      <= wait_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_wb_write_arbiter;

  localparam int Limit = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_RegWrite;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        llu_valid;
  logic [4:0]  llu_reg;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_RegWrite(wb_RegWrite),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .llu_valid  (llu_valid),
    .llu_reg    (llu_reg),
    .llu_data   (llu_data),
    .llu_ready  (llu_ready),
    .stall_req  (stall_req),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stall_cnt  (stall_cnt)
  );

  // Behavioural model: "losses" is how many cycles in a row the pending LLU
  // result has been refused; expected outputs follow from the grant rules.
  int          m_losses, n_losses;
  int          m_stalls, n_stalls;
  logic        m_we, n_we;
  logic [4:0]  m_waddr, n_waddr;
  logic [31:0] m_wdata, n_wdata;
  logic        e_ready, e_stall;

  task automatic model_eval();
    bit want;
    want = wb_RegWrite && (wb_reg != 0);
    if (!rst) begin
      e_ready = 0; e_stall = 0;
      n_losses = 0; n_stalls = 0; n_we = 0; n_waddr = 0; n_wdata = 0;
      return;
    end
    e_stall = want && llu_valid && (m_losses == Limit);
    e_ready = !want || e_stall;
    n_we = 0; n_waddr = m_waddr; n_wdata = m_wdata;
    if (llu_valid && e_ready) begin
      if (llu_reg != 0) begin n_we = 1; n_waddr = llu_reg; n_wdata = llu_data; end
    end else if (want) begin
      n_we = 1; n_waddr = wb_reg; n_wdata = wb_data;
    end
    if (!llu_valid || e_ready) n_losses = 0;
    else n_losses = m_losses + 1;
    n_stalls = (e_stall && m_stalls < 65535) ? m_stalls + 1 : m_stalls;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_losses = n_losses; m_stalls = n_stalls;
    m_we = n_we; m_waddr = n_waddr; m_wdata = n_wdata;
  endtask

  task automatic test_reset();
    rst = 0; wb_RegWrite = 1; wb_reg = 5; wb_data = 32'h1234_5678;
    llu_valid = 1; llu_reg = 9; llu_data = 32'h0BAD_F00D;
    @(posedge clk); #1;
    n_checks++;
    if (llu_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready got %b exp 0", llu_ready); end
    n_checks++;
    if (stall_req !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b exp 0", stall_req); end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_we got %b exp 0", rf_we); end
    n_checks++;
    if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      n_errors++; $display("FAIL reset_rf got %0d/%h exp 0/0", rf_waddr, rf_wdata);
    end
    n_checks++;
    if (stall_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_scnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_pipe_only();
    rst = 1; wb_RegWrite = 1; wb_reg = 5; wb_data = 32'hDEADBEEF; llu_valid = 0;
    #1;
    n_checks++;
    if (llu_ready !== 1'b0 || stall_req !== 1'b0) begin
      n_errors++; $display("FAIL pipe_comb got rdy=%b stall=%b exp 0/0", llu_ready, stall_req);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL pipe_write got %b/%0d/%h exp 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_free_port();
    wb_RegWrite = 1; wb_reg = 0; wb_data = 32'h5555_5555;
    llu_valid = 1; llu_reg = 9; llu_data = 7;
    #1;
    n_checks++;
    if (llu_ready !== 1'b1 || stall_req !== 1'b0) begin
      n_errors++; $display("FAIL free_comb got rdy=%b stall=%b exp 1/0", llu_ready, stall_req);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'd7) begin
      n_errors++; $display("FAIL free_write got %b/%0d/%0d exp 1/9/7", rf_we, rf_waddr, rf_wdata);
    end
    wb_RegWrite = 0; llu_valid = 0;
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd9 || rf_wdata !== 32'd7) begin
      n_errors++; $display("FAIL idle_hold got %b/%0d/%0d exp 0/9/7", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_starvation();
    llu_valid = 1; llu_reg = 20; llu_data = 32'hAAAA;
    wb_RegWrite = 1;
    for (int i = 0; i < 3; i++) begin
      wb_reg = 5'(10 + i); wb_data = 32'(100 + i);
      #1;
      n_checks++;
      if (llu_ready !== 1'b0 || stall_req !== 1'b0) begin
        n_errors++; $display("FAIL starve_lose%0d got rdy=%b stall=%b exp 0/0", i, llu_ready, stall_req);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(10 + i) || rf_wdata !== 32'(100 + i)) begin
        n_errors++;
        $display("FAIL starve_pipe%0d got %b/%0d/%0d exp 1/%0d/%0d", i, rf_we, rf_waddr, rf_wdata,
                 10 + i, 100 + i);
      end
    end
    wb_reg = 13; wb_data = 113;
    #1;
    n_checks++;
    if (llu_ready !== 1'b1 || stall_req !== 1'b1) begin
      n_errors++; $display("FAIL starve_force got rdy=%b stall=%b exp 1/1", llu_ready, stall_req);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_wdata !== 32'hAAAA || stall_cnt !== 16'd1) begin
      n_errors++;
      $display("FAIL starve_llu got %b/%0d/%h scnt=%0d exp 1/20/aaaa scnt=1", rf_we, rf_waddr,
               rf_wdata, stall_cnt);
    end
    llu_valid = 0;
    #1;
    n_checks++;
    if (stall_req !== 1'b0) begin n_errors++; $display("FAIL starve_nostall got %b exp 0", stall_req); end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd13 || rf_wdata !== 32'd113) begin
      n_errors++; $display("FAIL starve_resume got %b/%0d/%0d exp 1/13/113", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_llu_r0();
    wb_RegWrite = 0; llu_valid = 1; llu_reg = 0; llu_data = 55;
    #1;
    n_checks++;
    if (llu_ready !== 1'b1) begin n_errors++; $display("FAIL r0_ready got %b exp 1", llu_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b0) begin n_errors++; $display("FAIL r0_we got %b exp 0", rf_we); end
    llu_valid = 0;
  endtask

  task automatic test_mid_reset();
    wb_RegWrite = 1; wb_reg = 3; wb_data = 3;
    llu_valid = 1; llu_reg = 7; llu_data = 77;
    repeat (2) begin
      #1;
      n_checks++;
      if (llu_ready !== 1'b0) begin n_errors++; $display("FAIL mid_lose got %b exp 0", llu_ready); end
      @(posedge clk); #1;
    end
    rst = 0;
    #1;
    n_checks++;
    if (llu_ready !== 1'b0 || stall_req !== 1'b0) begin
      n_errors++; $display("FAIL mid_rst got rdy=%b stall=%b exp 0/0", llu_ready, stall_req);
    end
    @(posedge clk); #1;
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (stall_req !== 1'b0 || llu_ready !== 1'b0) begin
        n_errors++; $display("FAIL mid_wait%0d got rdy=%b stall=%b exp 0/0", i, llu_ready, stall_req);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (stall_req !== 1'b1) begin n_errors++; $display("FAIL mid_force got %b exp 1", stall_req); end
    @(posedge clk); #1;
    n_checks++;
    if (rf_waddr !== 5'd7 || rf_wdata !== 32'd77 || stall_cnt !== 16'd1) begin
      n_errors++;
      $display("FAIL mid_llu got %0d/%0d scnt=%0d exp 7/77 scnt=1", rf_waddr, rf_wdata, stall_cnt);
    end
    llu_valid = 0;
  endtask

  task automatic test_random();
    bit llu_pending = 0;
    bit hold_pipe = 0;
    for (int i = 0; i < 600; i++) begin
      rst = (i == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      if (!hold_pipe) begin
        wb_RegWrite = ($urandom_range(0, 3) != 0);
        wb_reg = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        wb_data = wb_RegWrite ? $urandom : 'x;
      end
      if (!llu_pending) begin
        llu_valid = ($urandom_range(0, 2) != 0);
        llu_reg = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        llu_data = llu_valid ? $urandom : 'x;
      end
      #1;
      model_eval();
      n_checks++;
      if (llu_ready !== e_ready || stall_req !== e_stall) begin
        n_errors++;
        $display("FAIL rand_comb@%0d got rdy=%b stall=%b exp %b/%b", i, llu_ready, stall_req,
                 e_ready, e_stall);
      end
      // Stalled MEM-WB re-presents its write; an unaccepted LLU result stays pending.
      hold_pipe = e_stall;
      llu_pending = llu_valid && !e_ready;
      advance();
      n_checks++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        n_errors++;
        $display("FAIL rand_rf@%0d got %b/%0d/%h exp %b/%0d/%h", i, rf_we, rf_waddr, rf_wdata,
                 m_we, m_waddr, m_wdata);
      end
      n_checks++;
      if (stall_cnt !== 16'(m_stalls)) begin
        n_errors++; $display("FAIL rand_scnt@%0d got %0d exp %0d", i, stall_cnt, m_stalls);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_free_port();
    test_starvation();
    test_llu_r0();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: maximum number of consecutive cycles a pending LLU result loses arbitration before the pipeline is stalled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising clk; rst=0 resets, rst=1 runs.
REQ-004 wb_RegWrite  input  1  register-write enable from the MEM-WB register.
REQ-005 wb_reg  input  5  destination register from the MEM-WB register.
REQ-006 wb_data  input  32  write-back data, already muxed by MemtoReg.
REQ-007 llu_valid  input  1  long-latency unit (mul/div) result pending.
REQ-008 llu_reg  input  5  LLU destination register.
REQ-009 llu_data  input  32  LLU result data.
REQ-010 llu_ready  output  1  combinational; LLU result accepted this cycle when llu_valid=1 and llu_ready=1.
REQ-011 stall_req  output  1  combinational; holds IF/ID/EX/MEM-WB registers for this cycle.
REQ-012 rf_we  output  1  registered register-file write enable.
REQ-013 rf_waddr  output  5  registered register-file write address.
REQ-014 rf_wdata  output  32  registered register-file write data.
REQ-015 stall_cnt  output  16  registered saturating count of forced stall cycles.

Function
REQ-016 pipe_wants = wb_RegWrite AND (wb_reg != 0); a write to r0 never consumes the port.
REQ-017 wait_cnt is a 4-bit register counting consecutive cycles with llu_valid=1 and llu_ready=0.
REQ-018 Normal grant: pipe_wants=1 and wait_cnt < STARVE_LIMIT -> pipeline wins; llu_ready=0; stall_req=0.
REQ-019 Free port: pipe_wants=0 -> llu_ready=1; stall_req=0.
REQ-020 Forced grant: pipe_wants=1, llu_valid=1, wait_cnt == STARVE_LIMIT -> llu_ready=1, stall_req=1; the pipeline write is deferred because MEM-WB holds its value and presents it again next cycle.
REQ-021 stall_req SHALL never be asserted when llu_valid=0.
REQ-022 stall_req SHALL never be asserted in two consecutive cycles.
REQ-023 wait_cnt update: cleared on any LLU handshake or when llu_valid=0; incremented when llu_valid=1 and llu_ready=0; never exceeds STARVE_LIMIT.
REQ-024 Write port, latency 1 cycle: the winner's reg/data are registered to rf_waddr/rf_wdata with rf_we=1.
REQ-025 If neither side writes, rf_we=0 next cycle and rf_waddr/rf_wdata hold their previous values.
REQ-026 LLU handshake with llu_reg=0 SHALL complete (llu_ready=1) but produce rf_we=0.
REQ-027 stall_cnt increments once per cycle with stall_req=1 and saturates at 16'hFFFF.
REQ-028 Simultaneous LLU handshake and forced stall in the same cycle is the normal forced-grant case; exactly one write is issued.
REQ-029 Outputs SHALL contain no X after the first reset, regardless of input X on unused data buses.

Reset
REQ-030 While rst=0 at a rising edge: rf_we=0, rf_waddr=0, rf_wdata=0, wait_cnt=0, stall_cnt=0.
REQ-031 While rst=0, llu_ready=0 and stall_req=0 combinationally; no handshake completes.
REQ-032 A reset asserted mid-wait discards wait_cnt; the LLU result remains pending and is arbitrated afresh after rst returns to 1.

Verification
REQ-033 Reset: rst=0 for 2 cycles with all inputs active -> rf_we=0, llu_ready=0, stall_req=0, stall_cnt=0.
REQ-034 Pipeline only: wb_RegWrite=1, wb_reg=5, wb_data=32'hDEADBEEF, llu_valid=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF.
REQ-035 Free port: wb_RegWrite=1, wb_reg=0, llu_valid=1, llu_reg=9, llu_data=7 -> llu_ready=1 same cycle; next cycle rf_waddr=9, rf_wdata=7.
REQ-036 Starvation, STARVE_LIMIT=3: pipe_wants=1 every cycle, llu_valid=1 from cycle 0 -> pipeline writes in cycles 0-2; cycle 3 stall_req=1, llu_ready=1; cycle 4 rf shows LLU write, stall_req=0, pipeline write resumes; stall_cnt=1.
REQ-037 LLU r0: llu_valid=1, llu_reg=0, pipe idle -> handshake completes; rf_we=0 next cycle.
REQ-038 Mid-wait reset: wait_cnt=2, rst=0 for one cycle, then contention -> forced stall occurs only after 3 further losing cycles.
